// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: byte width and receiver FSM states.
`timescale 1ns/1ps
package uart_rx_pkg;
  localparam int unsigned UART_BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;
endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; resets to the idle-high level.
`timescale 1ns/1ps
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: start-bit validation at mid-bit, mid-bit data/stop sampling,
// one uart_byte_ready pulse per good frame, one framing_err pulse per bad stop bit.
`timescale 1ns/1ps
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  output logic [UART_BYTE_WIDTH-1:0] uart_byte,
  output logic                       uart_byte_ready,
  output logic                       framing_err
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic                       rx_s;
  logic                       rx_prev;
  rx_state_t                  state, state_n;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic [2:0]                 bit_idx, bit_idx_n;
  logic [UART_BYTE_WIDTH-1:0] shreg, shreg_n;
  logic [UART_BYTE_WIDTH-1:0] byte_n;
  logic                       ready_n;
  logic                       ferr_n;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_prev         <= 1'b1;
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      uart_byte       <= '0;
      uart_byte_ready <= 1'b0;
      framing_err     <= 1'b0;
    end else begin
      rx_prev         <= rx_s;
      state           <= state_n;
      cnt             <= cnt_n;
      bit_idx         <= bit_idx_n;
      shreg           <= shreg_n;
      uart_byte       <= byte_n;
      uart_byte_ready <= ready_n;
      framing_err     <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    byte_n    = uart_byte;
    ready_n   = 1'b0;
    ferr_n    = 1'b0;

    case (state)
      IDLE: begin
        // Edge-triggered start: a line held low must be seen high before re-arming.
        if (rx_prev && !rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[UART_BYTE_WIDTH-1:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt == CNT_FULL) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            byte_n  = shreg;
            ready_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised from plain bit lists, expected pulses queued per frame.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int unsigned CPB = 16;
  localparam int unsigned LAT_MIN = 155;
  localparam int unsigned LAT_MAX = 157;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] uart_byte;
  logic       uart_byte_ready;
  logic       framing_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .uart_byte       (uart_byte),
    .uart_byte_ready (uart_byte_ready),
    .framing_err     (framing_err)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [7:0]  data;
    int unsigned fall_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  rx_log[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  logic        rst_at_edge = 1'b0;
  logic        seen_edge = 1'b0;
  logic [7:0]  last_good = 8'h00;
  logic        prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
    seen_edge   <= 1'b1;
  end

  always @(negedge clk) begin : monitor
    exp_t        e;
    int unsigned lat;
    if (seen_edge) begin
      if (!rst_at_edge) begin
        last_good  = 8'h00;
        prev_pulse = 1'b0;
        check("reset_ready", {31'd0, uart_byte_ready}, 32'd0);
        check("reset_ferr", {31'd0, framing_err}, 32'd0);
        check("reset_byte", {24'd0, uart_byte}, 32'd0);
      end else begin
        if (uart_byte_ready || framing_err) begin
          check("exclusive", {31'd0, uart_byte_ready & framing_err}, 32'd0);
          check("no_consecutive", {31'd0, prev_pulse}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse actual ready=%b ferr=%b byte=%h required no pulse",
                     uart_byte_ready, framing_err, uart_byte);
          end else begin
            e = exp_q.pop_front();
            check("pulse_ready", {31'd0, uart_byte_ready}, {31'd0, !e.is_err});
            check("pulse_ferr", {31'd0, framing_err}, {31'd0, e.is_err});
            if (!e.is_err) begin
              last_good = e.data;
              rx_log.push_back(uart_byte);
            end
            lat = cyc - e.fall_cyc;
            checks++;
            if (lat < LAT_MIN || lat > LAT_MAX) begin
              failures++;
              $display("FAIL latency actual=%0d required=%0d..%0d", lat, LAT_MIN, LAT_MAX);
            end
          end
        end
        check("byte_value", {24'd0, uart_byte}, {24'd0, last_good});
        prev_pulse = uart_byte_ready | framing_err;
      end
    end
  end

  task automatic hold(input logic v, input int unsigned n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    exp_t e;
    e.is_err   = !stop_bit;
    e.data     = data;
    e.fall_cyc = cyc;
    exp_q.push_back(e);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(data[i], CPB);
    hold(stop_bit, CPB);
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain actual=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #(60000 * 40);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  d;
    logic        s;
    int unsigned gap;

    // Reset held with the line toggling
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) hold(logic'(i % 2), 1);
    rst = 1'b1;
    hold(1'b1, 2 * CPB);

    // Single frame with latency window
    send_byte(8'hA5, 1'b1);
    hold(1'b1, CPB);
    wait_drain("single");
    check("byte_A5", {24'd0, uart_byte}, 32'h A5);

    // Back-to-back frames, no idle gap
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    hold(1'b1, CPB);
    wait_drain("b2b");
    check("byte_FF", {24'd0, uart_byte}, 32'h FF);

    // Glitch shorter than half a bit, then a real frame
    hold(1'b0, 4);
    hold(1'b1, 32);
    send_byte(8'h3C, 1'b1);
    hold(1'b1, CPB);
    wait_drain("glitch");
    check("byte_3C", {24'd0, uart_byte}, 32'h 3C);

    // Bad stop bit, then break, then recovery
    send_byte(8'h55, 1'b0);
    hold(1'b0, 48);
    hold(1'b1, CPB);
    wait_drain("framing");
    check("byte_kept_3C", {24'd0, uart_byte}, 32'h 3C);
    send_byte(8'h81, 1'b1);
    hold(1'b1, CPB);
    wait_drain("after_break");
    check("byte_81", {24'd0, uart_byte}, 32'h 81);

    // Reset during bit 4 of an 0xFF frame: nothing queued, so any pulse is flagged
    hold(1'b0, CPB);
    hold(1'b1, 4 * CPB + CPB / 2);
    rst = 1'b0;
    hold(1'b1, 3);
    rst = 1'b1;
    hold(1'b1, 2 * CPB);
    check("byte_after_reset", {24'd0, uart_byte}, 32'd0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    hold(1'b1, CPB);
    wait_drain("post_reset");
    checks++;
    if (rx_log.size() < 2 || {rx_log[rx_log.size()-2], rx_log[rx_log.size()-1]} !== 16'h1234) begin
      failures++;
      $display("FAIL word_1234 actual=%0d bytes received required=16'h1234", rx_log.size());
    end

    // Randomised frames; a bad stop bit is always followed by idle-high time
    for (int k = 0; k < 25; k++) begin
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send_byte(d, s);
      gap = s ? $urandom_range(0, 20) : $urandom_range(16, 40);
      if (gap > 0) hold(1'b1, gap);
    end
    hold(1'b1, CPB);
    wait_drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
